// File: rtl/amx_uart_tx.sv
// amx_uart_tx: captures amx_core1 output bytes into a small FIFO and sends each one as a UART frame.
// Define AMX_UART_PARITY_EN for 8E1 framing with an even parity bit; the default build is 8N1.
module amx_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  input  logic       chg_en,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef AMX_UART_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      prev_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            push, pop, do_push, baud_last;
`ifdef AMX_UART_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign overflow  = overflow_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign push      = wr_en | (chg_en & (data_in != prev_q));
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign do_push   = push & (~full | pop);
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q <= data_in;
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !do_push) count_q <= count_q - CW'(1);
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    baud_d    = baud_q;
    shreg_d   = shreg_q;
    pop       = 1'b0;
`ifdef AMX_UART_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
`ifdef AMX_UART_PARITY_EN
          parity_d = ^mem_q[rd_ptr_q];
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d    = '0;
          shreg_d   = shreg_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef AMX_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef AMX_UART_PARITY_EN
      S_PARITY: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_IDLE;
          // Chain straight into the next start bit so queued bytes go out with no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = mem_q[rd_ptr_q];
`ifdef AMX_UART_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != S_IDLE);
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_q[0];
`ifdef AMX_UART_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_idx_q <= 3'd0;
      baud_q    <= '0;
      shreg_q   <= 8'h00;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef AMX_UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      baud_q    <= baud_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef AMX_UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end
endmodule

// File: tb/tb_amx_uart_tx.sv
// Self-checking bench for amx_uart_tx: directed frame timing checks plus a line decoder
// that recovers bytes from the logged tx waveform and compares them with the pushed bytes.
module tb_amx_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef AMX_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL = FB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       wr_en = 1'b0;
  logic       chg_en = 1'b0;
  logic       tx, busy, full, empty, overflow;

  int n_tests = 0;
  int n_fail  = 0;
  bit logging = 1'b0;
  logic       txlog[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  amx_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .chg_en(chg_en),
    .tx(tx), .busy(busy), .full(full), .empty(empty), .overflow(overflow)
  );

  // Expected line level for bit slot i of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef AMX_UART_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (logging) txlog.push_back(tx);
  endtask

  // Receiver model: find each start bit in the log and sample every slot at mid-bit.
  task automatic decode();
    int i;
    logic [7:0] b;
    rx_q.delete();
    i = 0;
    while (i < txlog.size()) begin
      if (txlog[i] == 1'b0) begin
        if (i + (FB-1)*CPB + CPB/2 >= txlog.size()) break;
        check("start_bit", txlog[i + CPB/2], 1'b0);
        for (int k = 0; k < 8; k++) b[k] = txlog[i + (k+1)*CPB + CPB/2];
`ifdef AMX_UART_PARITY_EN
        check("parity_bit", txlog[i + 9*CPB + CPB/2], ^b);
`endif
        check("stop_bit", txlog[i + (FB-1)*CPB + CPB/2], 1'b1);
        rx_q.push_back(b);
        i = i + (FB-1)*CPB + CPB/2 + 1;
      end else begin
        i++;
      end
    end
  endtask

  task automatic compare_frames(input string tag);
    decode();
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int n = 0; n < rx_q.size() && n < exp_q.size(); n++) check(tag, rx_q[n], exp_q[n]);
    txlog.delete();
    exp_q.delete();
    logging = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int mode, gap;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      data_in = 8'($urandom);
      wr_en   = 1'($urandom);
      chg_en  = 1'($urandom);
      tick();
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_overflow", overflow, 1'b0);
    end
    wr_en = 0; chg_en = 0; data_in = 8'h00;
    tick();
    rst = 0;
    repeat (3) tick();

    // Single byte 0xA5: exact waveform and busy window.
    data_in = 8'hA5; wr_en = 1;
    tick();
    wr_en = 0;
    check("single_empty_after_push", empty, 1'b0);
    check("single_busy_before_pop", busy, 1'b0);
    tick();
    check("single_tx_idle_at_pop", tx, 1'b1);
    check("single_empty_after_pop", empty, 1'b1);
    for (int t = 0; t < FL; t++) begin
      tick();
      check("single_tx", tx, frame_bit(8'hA5, t / CPB));
      check("single_busy", busy, 1'b1);
    end
    tick();
    check("single_busy_end", busy, 1'b0);
    check("single_tx_end", tx, 1'b1);
    repeat (4) tick();

    // Back-to-back 0x01, 0x02.
    data_in = 8'h01; wr_en = 1;
    tick();
    data_in = 8'h02;
    tick();
    wr_en = 0;
    check("b2b_tx_idle", tx, 1'b1);
    check("b2b_empty_j1", empty, 1'b0);
    for (int j = 2; j < 2 + 2*FL + 2; j++) begin
      tick();
      b = (j - 2 < FL) ? 8'h01 : 8'h02;
      check("b2b_tx", tx, (j - 2 < 2*FL) ? frame_bit(b, ((j - 2) % FL) / CPB) : 1'b1);
      check("b2b_empty", empty, (j < 1 + FL) ? 1'b0 : 1'b1);
    end
    repeat (4) tick();

    // Change detect: 0x00 -> 0x3C -> 0x3C -> 0xC3.
    data_in = 8'h00;
    repeat (2) tick();
    logging = 1;
    chg_en = 1;
    tick();
    data_in = 8'h3C;
    repeat (2) tick();
    data_in = 8'hC3;
    repeat (3*FL) tick();
    chg_en = 0;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    compare_frames("chg_frame");

    // Overflow and pointer wrap.
    logging = 1;
    for (int i = 0; i < 6; i++) begin
      data_in = 8'(8'h10 + i); wr_en = 1;
      tick();
      if (i == 4) begin
        check("ovf_full_at_4", full, 1'b1);
        check("ovf_clear_at_4", overflow, 1'b0);
      end
      if (i == 5) check("ovf_set", overflow, 1'b1);
    end
    wr_en = 0;
    repeat (6*FL) tick();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h10 + i));
    compare_frames("ovf_frame");
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_drained", empty, 1'b1);
    rst = 1;
    #1;
    check("ovf_cleared_by_rst", overflow, 1'b0);
    tick();
    rst = 0;
    repeat (2) tick();

    // Randomized pushes via wr_en, change-detect, or both at once.
    logging = 1;
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom);
      mode = $urandom_range(0, 2);
      if (mode != 0 && b == data_in) b = b ^ 8'h01;
      data_in = b;
      wr_en   = (mode != 1);
      chg_en  = (mode != 0);
      tick();
      wr_en = 0; chg_en = 0;
      exp_q.push_back(b);
      gap = FL + 2 + $urandom_range(0, 20);
      data_in = 8'($urandom);
      repeat (gap) tick();
    end
    repeat (FL) tick();
    compare_frames("rand_frame");

    // Reset mid-frame: tx returns high at once and queued bytes are lost.
    data_in = 8'h55; wr_en = 1;
    tick();
    data_in = 8'h66;
    tick();
    wr_en = 0;
    repeat (FL/2) tick();
    check("midrst_busy_before", busy, 1'b1);
    rst = 1;
    #2;
    check("midrst_tx_async", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_empty", empty, 1'b1);
    repeat (2) tick();
    rst = 0;
    logging = 1;
    repeat (3*FL) tick();
    compare_frames("midrst_frame");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
